// File: rtl/wb_register_file_pkg.sv
// Shared pipeline constants for the write-back register file and its consumers.
package wb_register_file_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  // Link register targeted by jal when the WB mux selects the return PC.
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam int         WRITE_COUNT_W   = 16;
  localparam logic [15:0] WRITE_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/wb_register_file_if.sv
// Bus bundle between MEM/WB + ID + debug and the architectural register file.
interface wb_register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              HiLoWrite;
  logic [DATA_W-1:0] HiIn;
  logic [DATA_W-1:0] LoIn;
  logic [DATA_W-1:0] HiOut;
  logic [DATA_W-1:0] LoOut;
  logic [ADDR_W-1:0] DbgReg;
  logic [DATA_W-1:0] DbgData;
  logic [15:0]       WriteCount;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    output HiLoWrite, HiIn, LoIn, DbgReg,
    input  ReadData1, ReadData2, HiOut, LoOut, DbgData, WriteCount
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    input  HiLoWrite, HiIn, LoIn, DbgReg,
    output ReadData1, ReadData2, HiOut, LoOut, DbgData, WriteCount
  );

endinterface

// File: rtl/wb_register_file_reg_read_bypass.sv
// One read port: zero override, then same-cycle write forwarding, then stored value.
module reg_read_bypass #(
  parameter int DATA_W = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic [DATA_W-1:0] storedData,
  input  logic [DATA_W-1:0] writeData,
  input  logic              writeHit,
  input  logic              isZero,
  output logic [DATA_W-1:0] readData
);

  always_comb begin
    readData = storedData;
    if (isZero) begin
      readData = '0;
    end else if (BYPASS && writeHit) begin
      readData = writeData;
    end
  end

endmodule

// File: rtl/wb_register_file.sv
// Architectural GPR file with HI/LO pair, debug port and saturating commit counter.
module wb_register_file #(
  parameter int DATA_W = wb_register_file_pkg::DATA_W,
  parameter int ADDR_W = wb_register_file_pkg::ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic                Clk,
  input  logic                Rst,
  wb_register_file_if.slave   bus
);
  import wb_register_file_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regFile [DEPTH];
  logic [DATA_W-1:0] hiReg;
  logic [DATA_W-1:0] loReg;
  logic [WRITE_COUNT_W-1:0] writeCount;

  logic gprCommit;
  logic hit1, hit2, hiLoHit;
  logic [DATA_W-1:0] rd1, rd2, hiOut, loOut;

  assign gprCommit = bus.RegWrite && (bus.WriteReg != ZERO_IDX);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) regFile[i] <= '0;
      hiReg      <= '0;
      loReg      <= '0;
      writeCount <= '0;
    end else begin
      if (gprCommit) begin
        regFile[bus.WriteReg] <= bus.WriteData;
        if (writeCount != WRITE_COUNT_MAX) writeCount <= writeCount + 16'd1;
      end
      if (bus.HiLoWrite) begin
        hiReg <= bus.HiIn;
        loReg <= bus.LoIn;
      end
    end
  end

  // Forwarding is suppressed while in reset so every output reads zero.
  assign hit1    = Rst && gprCommit && (bus.ReadReg1 == bus.WriteReg);
  assign hit2    = Rst && gprCommit && (bus.ReadReg2 == bus.WriteReg);
  assign hiLoHit = Rst && bus.HiLoWrite;

  reg_read_bypass #(.DATA_W(DATA_W), .BYPASS(BYPASS)) uRead1 (
    .storedData (regFile[bus.ReadReg1]),
    .writeData  (bus.WriteData),
    .writeHit   (hit1),
    .isZero     (bus.ReadReg1 == ZERO_IDX),
    .readData   (rd1)
  );

  reg_read_bypass #(.DATA_W(DATA_W), .BYPASS(BYPASS)) uRead2 (
    .storedData (regFile[bus.ReadReg2]),
    .writeData  (bus.WriteData),
    .writeHit   (hit2),
    .isZero     (bus.ReadReg2 == ZERO_IDX),
    .readData   (rd2)
  );

  reg_read_bypass #(.DATA_W(DATA_W), .BYPASS(BYPASS)) uReadHi (
    .storedData (hiReg),
    .writeData  (bus.HiIn),
    .writeHit   (hiLoHit),
    .isZero     (1'b0),
    .readData   (hiOut)
  );

  reg_read_bypass #(.DATA_W(DATA_W), .BYPASS(BYPASS)) uReadLo (
    .storedData (loReg),
    .writeData  (bus.LoIn),
    .writeHit   (hiLoHit),
    .isZero     (1'b0),
    .readData   (loOut)
  );

  assign bus.ReadData1  = rd1;
  assign bus.ReadData2  = rd2;
  assign bus.HiOut      = hiOut;
  assign bus.LoOut      = loOut;
  assign bus.DbgData    = regFile[bus.DbgReg];
  assign bus.WriteCount = writeCount;

endmodule

// File: doc/wb_register_file.md
Name: wb_register_file

Overview:
- Architectural register file at the receiving end of the write-back path; consumes the write-back mux output (ALU result / load data / return PC) plus RegWrite and the destination index from MEM/WB.
- Supplies two operand read ports to ID, a HI/LO register pair for multiply/divide results, and one debug read port for board display.
- Writes commit on the rising clock edge. Reads are combinational with write-to-read bypass, so ID sees a same-cycle WB value without a separate stall.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous reset, active-low.
- RegWrite  in  1  commit WriteData to WriteReg this edge.
- WriteReg  in  ADDR_W  destination index from MEM/WB.
- WriteData  in  DATA_W  write-back mux output.
- ReadReg1  in  ADDR_W  rs index.
- ReadReg2  in  ADDR_W  rt index.
- ReadData1  out  DATA_W  rs value.
- ReadData2  out  DATA_W  rt value.
- HiLoWrite  in  1  commit HiIn/LoIn this edge.
- HiIn  in  DATA_W  multiply/divide upper result.
- LoIn  in  DATA_W  multiply/divide lower result.
- HiOut  out  DATA_W  HI value (bypassed like GPRs).
- LoOut  out  DATA_W  LO value (bypassed like GPRs).
- DbgReg  in  ADDR_W  debug index.
- DbgData  out  DATA_W  debug value; no bypass, stored value only.
- WriteCount  out  16  committed GPR writes since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (Rst=0, asynchronous):
  - All GPRs, HI, LO and WriteCount clear to 0 immediately, independent of Clk.
  - Outputs then read 0 for every index.
  - Writes presented while Rst=0 are discarded.
  - Deassertion is synchronous to the design; the first edge after release may commit.
- GPR write:
  - On a rising edge with RegWrite=1 and WriteReg!=0, reg[WriteReg] <= WriteData.
  - Latency: 1 edge to storage.
- Register 0:
  - Hardwired zero. A write to index 0 is dropped and does not increment WriteCount.
  - Any read of index 0 returns 0 on all ports, bypass included.
- Read ports:
  - Purely combinational from index to data.
  - With BYPASS=1, when RegWrite=1, WriteReg!=0 and ReadRegN==WriteReg, ReadDataN = WriteData in the same cycle.
  - Otherwise ReadDataN = stored reg[ReadRegN].
  - Both ports may address the same index, and either may match the write index simultaneously; each port resolves independently.
- HI/LO:
  - On a rising edge with HiLoWrite=1, HI <= HiIn and LO <= LoIn, both in the same edge.
  - With BYPASS=1, HiOut = HiIn and LoOut = LoIn while HiLoWrite=1.
  - A GPR write and a HI/LO write in the same cycle both commit; they are independent.
- WriteCount:
  - Increments by 1 on each committed GPR write (RegWrite=1, WriteReg!=0).
  - Holds at 16'hFFFF; no wrap-around.
- BYPASS=0: read ports, HiOut and LoOut show only stored values; a same-cycle write is visible after the edge.
- X-safety: RegWrite=0 never modifies state, whatever WriteReg/WriteData hold.

Decomposition:
- Shared package (pipeline constants):
  - DATA_W, ADDR_W.
  - REG_ZERO = 5'd0.
  - REG_RA = 5'd31, used by the jal path that writes PC through the WB mux.
- One natural sub-module: reg_read_bypass.
  - Combinational per-port mux of stored value, write data and zero.
  - Instantiated for ReadData1, ReadData2, HiOut and LoOut.
- Storage, HI/LO registers and the counter stay in the top module.

Test Plan:
- Reset: load reg 5 = 32'hDEADBEEF, pull Rst low mid-cycle -> ReadData1 (ReadReg1=5) = 0 immediately, before the next edge; WriteCount = 0.
- Write/read: RegWrite=1, WriteReg=8, WriteData=32'h12345678, then RegWrite=0 -> ReadReg2=8 gives 32'h12345678 after the edge; WriteCount = 1.
- Zero register: write 32'hFFFFFFFF to index 0 -> ReadData1/2 at index 0 = 0 in the same cycle and after; WriteCount unchanged.
- Bypass: reg 31 holds 32'h0, write 32'h00400020 to 31 with ReadReg1=ReadReg2=31:
  - BYPASS=1 -> both ports show 32'h00400020 before the edge.
  - BYPASS=0 -> both show 0 until the edge.
- HI/LO plus GPR in one cycle: HiLoWrite=1 (HiIn=32'h1, LoIn=32'h2) with RegWrite=1 to reg 3 = 32'h3 -> after the edge HiOut=1, LoOut=2, reg 3=3; DbgReg=3 gives DbgData=3.
- Saturation: force 65535 committed writes, then one more -> WriteCount stays 16'hFFFF.
